// File: rtl/btn_uart_tx.sv
// btn_uart_tx
//   Transmit stage placed after the push-button debouncer. A one-cycle
//   request pulse sends the byte on the switches as one 8N1 UART frame.
//   The block holds one pending request, so a press that arrives
//   mid-frame is sent right after the current frame.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   start_tick    one-cycle request pulse (debouncer db_tick)
//   din           byte to send, sampled only while start_tick is high
//   tx            serial line, idles high
//   tx_busy       high whenever the FSM is not in IDLE
//   tx_done_tick  one-cycle pulse at the end of each frame's stop bit
//   pend_valid    a request is queued behind the current frame
module btn_uart_tx #(
  parameter int DBIT      = 8,
  parameter int SB_TICK   = 16,
  parameter int BAUD_DVSR = 326,
  parameter int DVSR_W    = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_tick,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            pend_valid
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] START = 2'b01;
  localparam logic [1:0] DATA  = 2'b10;
  localparam logic [1:0] STOP  = 2'b11;

  localparam int BIT_W  = (DBIT > 1) ? $clog2(DBIT) : 1;
  // Tick counter must cover both the 16-tick data bits and the stop bit.
  localparam int TICK_W = $clog2((SB_TICK > 16) ? SB_TICK : 16);

  localparam logic [DVSR_W-1:0] BAUD_LAST = DVSR_W'(BAUD_DVSR - 1);
  localparam logic [TICK_W-1:0] BIT_TICKS = TICK_W'(15);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DBIT - 1);

  logic [1:0]        r_state;
  logic [DVSR_W-1:0] r_baud;
  logic [TICK_W-1:0] r_tick;
  logic [BIT_W-1:0]  r_bit;
  logic [DBIT-1:0]   r_sh;
  logic [DBIT-1:0]   r_pend;
  logic              r_pend_v;
  logic              r_tx;
  logic              r_done;

  logic [1:0]        w_state_n;
  logic [TICK_W-1:0] w_tick_n;
  logic [BIT_W-1:0]  w_bit_n;
  logic [DBIT-1:0]   w_sh_n;
  logic [DBIT-1:0]   w_pend_n;
  logic              w_pend_v_n;
  logic              w_done_n;
  logic              w_tx_n;
  logic              w_s_tick;
  logic              w_stop_end;

  // Oversample tick; the baud counter is parked at 0 in IDLE so every
  // frame begins phase-aligned with the request.
  assign w_s_tick   = (r_state != IDLE) && (r_baud == BAUD_LAST);
  assign w_stop_end = (r_state == STOP) && w_s_tick && (r_tick == STOP_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baud <= '0;
    end else if (r_state == IDLE) begin
      r_baud <= '0;
    end else if (r_baud == BAUD_LAST) begin
      r_baud <= '0;
    end else begin
      r_baud <= r_baud + 1'b1;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_tick_n   = r_tick;
    w_bit_n    = r_bit;
    w_sh_n     = r_sh;
    w_pend_n   = r_pend;
    w_pend_v_n = r_pend_v;
    w_done_n   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_tick) begin
          w_sh_n    = din;
          w_tick_n  = '0;
          w_state_n = START;
        end
      end
      START: begin
        if (w_s_tick) begin
          if (r_tick == BIT_TICKS) begin
            w_tick_n  = '0;
            w_bit_n   = '0;
            w_state_n = DATA;
          end else begin
            w_tick_n = r_tick + 1'b1;
          end
        end
      end
      DATA: begin
        if (w_s_tick) begin
          if (r_tick == BIT_TICKS) begin
            w_tick_n = '0;
            w_sh_n   = r_sh >> 1;
            if (r_bit == BIT_LAST) begin
              w_state_n = STOP;
            end else begin
              w_bit_n = r_bit + 1'b1;
            end
          end else begin
            w_tick_n = r_tick + 1'b1;
          end
        end
      end
      default: begin // STOP
        if (w_s_tick) begin
          if (r_tick == STOP_LAST) begin
            w_done_n = 1'b1;
            w_tick_n = '0;
            // A request in the completing cycle is fresher than any
            // queued byte, so it is sent and the queue is dropped.
            if (start_tick) begin
              w_sh_n     = din;
              w_pend_v_n = 1'b0;
              w_state_n  = START;
            end else if (r_pend_v) begin
              w_sh_n     = r_pend;
              w_pend_v_n = 1'b0;
              w_state_n  = START;
            end else begin
              w_state_n = IDLE;
            end
          end else begin
            w_tick_n = r_tick + 1'b1;
          end
        end
      end
    endcase
    // Requests while busy go to the single pending slot; newest wins.
    if (start_tick && (r_state != IDLE) && !w_stop_end) begin
      w_pend_n   = din;
      w_pend_v_n = 1'b1;
    end
  end

  // The line level is derived from the next state so tx changes on the
  // same edge as the state, giving one clock from request to start bit.
  always_comb begin
    case (w_state_n)
      START:   w_tx_n = 1'b0;
      DATA:    w_tx_n = w_sh_n[0];
      default: w_tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_tick   <= '0;
      r_bit    <= '0;
      r_sh     <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_tx     <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_tick   <= w_tick_n;
      r_bit    <= w_bit_n;
      r_sh     <= w_sh_n;
      r_pend   <= w_pend_n;
      r_pend_v <= w_pend_v_n;
      r_tx     <= w_tx_n;
      r_done   <= w_done_n;
    end
  end

  assign tx           = r_tx;
  assign tx_busy      = (r_state != IDLE);
  assign tx_done_tick = r_done;
  assign pend_valid   = r_pend_v;

endmodule
